// File: rtl/blocking.sv
// Sampling register built from a chain of DEPTH stages updated in one clocked process.
// Default build collapses the chain (latency 1); BLOCKING_NONBLOCKING_EN makes it a true shift register.
module blocking #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [WIDTH-1:0]         A,
  output logic [WIDTH-1:0]         F,
  output logic [DEPTH*WIDTH-1:0]   Taps,
  output logic                     Valid
);

  localparam int unsigned CNT_W_RAW = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
`ifdef BLOCKING_NONBLOCKING_EN
  localparam int unsigned TARGET    = DEPTH;
`else
  localparam int unsigned TARGET    = 1;
`endif
  localparam logic [CNT_W-1:0] FILL_TARGET = CNT_W'(TARGET);

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [CNT_W-1:0] r_fill;
  logic             r_valid;
  logic [CNT_W-1:0] w_fill_next;

  // Saturating count of non-reset edges since reset
  always_comb begin
    w_fill_next = r_fill;
    if (r_fill != FILL_TARGET) begin
      w_fill_next = r_fill + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_stage[i] <= '0;
      end
      r_fill  <= '0;
      r_valid <= 1'b0;
    end else begin
`ifdef BLOCKING_NONBLOCKING_EN
      // Each stage takes its predecessor's old value: true shift register
      r_stage[0] <= A;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
`else
      // Sequential blocking chain collapses: every stage sees the same A
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_stage[i] <= A;
      end
`endif
      r_fill  <= w_fill_next;
      r_valid <= (w_fill_next == FILL_TARGET);
    end
  end

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_taps
    assign Taps[g*WIDTH +: WIDTH] = r_stage[g];
  end

  assign F     = r_stage[DEPTH-1];
  assign Valid = r_valid;

endmodule

// File: tb/tb_blocking.sv
// Self-checking bench for blocking: four configurations checked against a sample-history model.
module tb_blocking;

`ifdef BLOCKING_NONBLOCKING_EN
  localparam bit NB = 1'b1;
`else
  localparam bit NB = 1'b0;
`endif

  logic       Clock;
  logic       Reset;
  logic [7:0] a_in [4];

  logic [0:0]  f0;  logic [1:0]  t0;  logic v0;
  logic [7:0]  f1;  logic [31:0] t1;  logic v1;
  logic [0:0]  f2;  logic [0:0]  t2;  logic v2;
  logic [3:0]  f3;  logic [11:0] t3;  logic v3;

  blocking #(.WIDTH(1), .DEPTH(2)) u0 (.Clock(Clock), .Reset(Reset), .A(a_in[0][0:0]), .F(f0), .Taps(t0), .Valid(v0));
  blocking #(.WIDTH(8), .DEPTH(4)) u1 (.Clock(Clock), .Reset(Reset), .A(a_in[1]),      .F(f1), .Taps(t1), .Valid(v1));
  blocking #(.WIDTH(1), .DEPTH(1)) u2 (.Clock(Clock), .Reset(Reset), .A(a_in[2][0:0]), .F(f2), .Taps(t2), .Valid(v2));
  blocking #(.WIDTH(4), .DEPTH(3)) u3 (.Clock(Clock), .Reset(Reset), .A(a_in[3][3:0]), .F(f3), .Taps(t3), .Valid(v3));

  logic [7:0]  f_act [4];
  logic [31:0] taps_act [4];
  logic        valid_act [4];

  always_comb begin
    f_act[0] = 8'(f0);  taps_act[0] = 32'(t0);  valid_act[0] = v0;
    f_act[1] = f1;      taps_act[1] = t1;       valid_act[1] = v1;
    f_act[2] = 8'(f2);  taps_act[2] = 32'(t2);  valid_act[2] = v2;
    f_act[3] = 8'(f3);  taps_act[3] = 32'(t3);  valid_act[3] = v3;
  end

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Model: per-DUT history of A samples since reset, newest first
  logic [7:0] hist [4][16];
  int         cnt  [4];

  function automatic int dep_of(input int d);
    case (d)
      0: return 2;
      1: return 4;
      2: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int wid_of(input int d);
    case (d)
      0: return 1;
      1: return 8;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [7:0] mask(input int d, input logic [7:0] v);
    return v & 8'((1 << wid_of(d)) - 1);
  endfunction

  function automatic logic [7:0] exp_stage(input int d, input int i);
    if (NB) return (i < cnt[d]) ? hist[d][i] : 8'h00;
    return (cnt[d] > 0) ? hist[d][0] : 8'h00;
  endfunction

  function automatic logic [7:0] exp_f(input int d);
    return exp_stage(d, dep_of(d) - 1);
  endfunction

  function automatic logic [31:0] exp_taps(input int d);
    logic [31:0] t = '0;
    for (int i = 0; i < dep_of(d); i++) t |= 32'(exp_stage(d, i)) << (i * wid_of(d));
    return t;
  endfunction

  function automatic logic exp_valid(input int d);
    return cnt[d] >= (NB ? dep_of(d) : 1);
  endfunction

  // One clock edge with the current a_in; model tracks the edge, outputs sampled 1ns later
  task automatic step(input logic rst);
    Reset = rst;
    @(posedge Clock);
    for (int d = 0; d < 4; d++) begin
      if (rst) cnt[d] = 0;
      else begin
        for (int i = 15; i > 0; i--) hist[d][i] = hist[d][i-1];
        hist[d][0] = mask(d, a_in[d]);
        if (cnt[d] < 16) cnt[d]++;
      end
    end
    #1;
  endtask

  task automatic set_all(input logic [7:0] v);
    for (int d = 0; d < 4; d++) a_in[d] = v;
  endtask

  task automatic test_powerup;
    for (int d = 0; d < 4; d++) a_in[d] = 8'($urandom);
    step(1'b0);
    for (int d = 0; d < 4; d++) begin
      if (!NB || dep_of(d) == 1) begin
        checks++;
        if (f_act[d] !== exp_f(d)) begin
          errors++; $display("FAIL powerup_f dut%0d got %0h exp %0h", d, f_act[d], exp_f(d));
        end
      end
    end
  endtask

  task automatic test_reset;
    for (int d = 0; d < 4; d++) a_in[d] = 8'($urandom);
    step(1'b1);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (f_act[d] !== 8'h00 || taps_act[d] !== 32'h0 || valid_act[d] !== 1'b0) begin
        errors++; $display("FAIL reset dut%0d got f=%0h taps=%0h v=%0b exp all 0", d, f_act[d], taps_act[d], valid_act[d]);
      end
    end
  endtask

  task automatic test_basic;
    logic [7:0] seq [4] = '{8'h00, 8'h01, 8'h00, 8'h00};
    step(1'b1);
    for (int k = 0; k < 4; k++) begin
      set_all(seq[k]);
      step(1'b0);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (f_act[d] !== exp_f(d) || valid_act[d] !== exp_valid(d)) begin
          errors++; $display("FAIL basic dut%0d step%0d got f=%0h v=%0b exp f=%0h v=%0b", d, k, f_act[d], valid_act[d], exp_f(d), exp_valid(d));
        end
      end
    end
  endtask

  task automatic test_collapse;
    step(1'b1);
    set_all(8'hA5);
    step(1'b0);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (taps_act[d] !== exp_taps(d) || f_act[d] !== exp_f(d)) begin
        errors++; $display("FAIL collapse dut%0d got taps=%0h f=%0h exp taps=%0h f=%0h", d, taps_act[d], f_act[d], exp_taps(d), exp_f(d));
      end
    end
    if (!NB) begin
      checks++;
      if (t1 !== 32'hA5A5A5A5 || f1 !== 8'hA5) begin
        errors++; $display("FAIL collapse_u1 got taps=%0h f=%0h exp taps=a5a5a5a5 f=a5", t1, f1);
      end
    end
  endtask

  task automatic test_reset_priority;
    set_all(8'hFF);
    step(1'b1);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (f_act[d] !== 8'h00 || taps_act[d] !== 32'h0 || valid_act[d] !== 1'b0) begin
        errors++; $display("FAIL rst_prio dut%0d got f=%0h taps=%0h v=%0b exp all 0", d, f_act[d], taps_act[d], valid_act[d]);
      end
    end
    step(1'b0);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (f_act[d] !== exp_f(d) || valid_act[d] !== exp_valid(d)) begin
        errors++; $display("FAIL rst_release dut%0d got f=%0h v=%0b exp f=%0h v=%0b", d, f_act[d], valid_act[d], exp_f(d), exp_valid(d));
      end
    end
  endtask

  task automatic test_midstream;
    logic [7:0] seq [3] = '{8'h01, 8'h00, 8'h01};
    for (int k = 0; k < 3; k++) begin
      set_all(seq[k]);
      step(1'b0);
    end
    step(1'b1);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (f_act[d] !== 8'h00 || taps_act[d] !== 32'h0 || valid_act[d] !== 1'b0) begin
        errors++; $display("FAIL midstream_rst dut%0d got f=%0h taps=%0h v=%0b exp all 0", d, f_act[d], taps_act[d], valid_act[d]);
      end
    end
    set_all(8'h01);
    step(1'b0);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (f_act[d] !== exp_f(d) || taps_act[d] !== exp_taps(d)) begin
        errors++; $display("FAIL midstream_resume dut%0d got f=%0h taps=%0h exp f=%0h taps=%0h", d, f_act[d], taps_act[d], exp_f(d), exp_taps(d));
      end
    end
  endtask

  task automatic test_toggle;
    logic [7:0] v = 8'h00;
    step(1'b1);
    for (int k = 0; k < 8; k++) begin
      v = ~v;
      set_all(v);
      step(1'b0);
      checks++;
      if (f2 !== v[0:0]) begin
        errors++; $display("FAIL toggle_d1 step%0d got %0b exp %0b", k, f2, v[0]);
      end
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 300; k++) begin
      for (int d = 0; d < 4; d++) a_in[d] = 8'($urandom);
      step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (f_act[d] !== exp_f(d) || taps_act[d] !== exp_taps(d) || valid_act[d] !== exp_valid(d)) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d got f=%0h taps=%0h v=%0b exp f=%0h taps=%0h v=%0b",
                   d, k, f_act[d], taps_act[d], valid_act[d], exp_f(d), exp_taps(d), exp_valid(d));
        end
      end
    end
  endtask

  initial begin
    Reset = 1'b0;
    set_all(8'h00);
    for (int d = 0; d < 4; d++) cnt[d] = 0;
    test_powerup;
    test_reset;
    test_basic;
    test_collapse;
    test_reset_priority;
    test_midstream;
    test_toggle;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
